// File: rtl/countdown_display_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_display_pkg : shared FSM encoding, 7-segment codes and BCD helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package countdown_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  localparam logic [6:0] SEG_OFF      = 7'h7F;
  localparam logic [9:0] BCD_MAX      = 10'd999;
  localparam int         SHIFT_CYCLES = 10;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin2bcd_seq : sequential 10-bit binary to 3-digit BCD (shift-add-3)
// Rev 1.0
// ----------------------------------------------------------------------------
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  din,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [9:0]  value
);
  import countdown_display_pkg::*;

  conv_state_e r_state;
  conv_state_e w_state_nxt;
  logic [9:0]  r_bin;
  logic [9:0]  r_value;
  logic [11:0] r_scratch;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [11:0] w_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 4'(SHIFT_CYCLES - 1)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_adj = {dabble(r_scratch[11:8]), dabble(r_scratch[7:4]), dabble(r_scratch[3:0])};
  end

  // r_value keeps the raw input so an out-of-range second does not retrigger forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_value   <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (r_state != ST_IDLE);
      case (r_state)
        ST_LOAD: begin
          r_bin     <= (din > BCD_MAX) ? BCD_MAX : din;
          r_value   <= din;
          r_scratch <= '0;
          r_cnt     <= '0;
        end
        ST_SHIFT: begin
          r_scratch <= {w_adj[10:0], r_bin[9]};
          r_bin     <= {r_bin[8:0], 1'b0};
          r_cnt     <= r_cnt + 4'd1;
        end
        ST_DONE: r_bcd <= r_scratch;
        default: ;
      endcase
    end
  end

  assign bcd   = r_bcd;
  assign busy  = r_busy;
  assign done  = (r_state == ST_DONE);
  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/countdown_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_display : countdown value to multiplexed 7-segment display driver
// Rev 1.0
// ----------------------------------------------------------------------------
module countdown_display #(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetclock_n,
  input  logic [9:0]            second,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [11:0]           bcd,
  output logic                  busy,
  output logic                  timeout
);
  import countdown_display_pkg::*;

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [9:0]            r_last;
  logic                  r_conv_once;
  logic [9:0]            r_prev_sec;
  logic [PRE_W-1:0]      r_pre;
  logic [DIG_W-1:0]      r_dig;
  logic                  w_start;
  logic                  w_done;
  logic [9:0]            w_value;
  logic [31:0]           w_dig_idx;
  logic                  w_on;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_an;

  assign w_start = !r_conv_once || (second != r_last);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (resetclock_n),
    .start (w_start),
    .din   (second),
    .bcd   (bcd),
    .busy  (busy),
    .done  (w_done),
    .value (w_value)
  );

  always_ff @(posedge clk or negedge resetclock_n) begin
    if (!resetclock_n) begin
      r_last      <= '0;
      r_conv_once <= 1'b0;
    end else if (w_done) begin
      r_last      <= w_value;
      r_conv_once <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetclock_n) begin
    if (!resetclock_n) begin
      r_pre <= '0;
      r_dig <= '0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_dig <= (r_dig == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_dig + DIG_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Leading-zero suppression: tens dark only when hundreds are also zero.
  always_comb begin
    w_dig_idx = 32'(r_dig);
    w_on      = 1'b0;
    w_seg     = SEG_OFF;
    case (w_dig_idx)
      32'd0: begin
        w_on  = 1'b1;
        w_seg = seg_decode(bcd[3:0]);
      end
      32'd1: begin
        w_on  = (bcd[11:8] != 4'd0) || (bcd[7:4] != 4'd0);
        w_seg = seg_decode(bcd[7:4]);
      end
      32'd2: begin
        w_on  = (bcd[11:8] != 4'd0);
        w_seg = seg_decode(bcd[11:8]);
      end
      default: ;
    endcase
    if (blank || !w_on) begin
      w_on  = 1'b0;
      w_seg = SEG_OFF;
    end
    w_an = w_on ? ~(NUM_DIGITS'(1) << r_dig) : '1;
  end

  always_ff @(posedge clk or negedge resetclock_n) begin
    if (!resetclock_n) begin
      seg        <= SEG_OFF;
      an         <= '1;
      dp         <= 1'b1;
      r_prev_sec <= '0;
      timeout    <= 1'b0;
    end else begin
      seg        <= w_seg;
      an         <= w_an;
      dp         <= 1'b1;
      r_prev_sec <= second;
      timeout    <= (r_prev_sec != 10'd0) && (second == 10'd0);
    end
  end

endmodule
`default_nettype wire
